// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional parity bit, then the stop period.
// tx is registered and starts the edge after tx_start is accepted; tx_start is ignored while tx_busy is high.
module uart_tx #(
    parameter int BIT_WIDTH  = 16,
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] tx_din,
    output logic            tx_busy,
    output logic            tx_done,
    output logic            tx
);

    localparam int BW_W = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
    localparam int SB_W = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
    localparam int SW   = (BW_W > SB_W) ? BW_W : SB_W;
    localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int B1   = (DBIT > 1) ? 1 : 0;

    localparam logic [SW-1:0] BIT_LAST  = SW'(BIT_WIDTH - 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);
    localparam logic          PAR_ON    = (PARITY_EN != 0);
    localparam logic          ODD_BIT   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_cnt_q, s_cnt_d;
    logic [NW-1:0]   n_cnt_q, n_cnt_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            b_q     <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            b_q     <= b_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // tx_d carries the level of the bit being entered, so the line changes on the same edge as the state.
    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        b_d     = b_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_start) begin
                    b_d     = tx_din;
                    par_d   = (^tx_din) ^ ODD_BIT;
                    s_cnt_d = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt_q == BIT_LAST) begin
                        s_cnt_d = '0;
                        n_cnt_d = '0;
                        state_d = DATA;
                        tx_d    = b_q[0];
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == BIT_LAST) begin
                        s_cnt_d = '0;
                        b_d     = b_q >> 1;
                        if (n_cnt_q == N_LAST) begin
                            n_cnt_d = '0;
                            if (PAR_ON) begin
                                state_d = PARITY;
                                tx_d    = par_q;
                            end else begin
                                state_d = STOP;
                                tx_d    = 1'b1;
                            end
                        end else begin
                            n_cnt_d = n_cnt_q + NW'(1);
                            tx_d    = b_q[B1];
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_cnt_q == BIT_LAST) begin
                        s_cnt_d = '0;
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_cnt_q == STOP_LAST) begin
                        s_cnt_d = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                s_cnt_d = '0;
                n_cnt_d = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx_busy = (state_q != IDLE);
    assign tx_done = done_q;
    assign tx      = tx_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, the transmit-side counterpart of the existing oversampled UART receiver. It serialises a DBIT-wide word into an LSB-first frame: a start bit, the data bits, an optional parity bit, and a stop period. Bit timing comes from the shared s_tick baud-rate generator. The block sits between the TX FIFO read side and the serial pin.

Parameters:
BIT_WIDTH, 16, s_ticks per start/data/parity bit (oversampling factor)
DBIT, 8, data bits per frame
SB_TICK, 16, s_ticks in stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2)
PARITY_EN, 0, 1 inserts a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
s_tick  input  1  one-clk-wide baud oversampling tick
tx_start  input  1  request to send tx_din; sampled only in IDLE
tx_din  input  DBIT  word to transmit; captured on the accepted tx_start
tx_busy  output  1  high whenever the state is not IDLE
tx_done  output  1  one-clk pulse marking frame completion
tx  output  1  serial line; registered; idle high

Behaviour:
- Reset (async, rst_n=0): state=IDLE; s_cnt=0; n_cnt=0; b_reg=0; tx=1; tx_done=0; tx_busy=0. A reset mid-frame aborts the frame and returns tx to 1 immediately. No tx_done is issued for an aborted frame.
- Counters: s_cnt is sized max($clog2(BIT_WIDTH), $clog2(SB_TICK)). n_cnt is sized $clog2(DBIT). Counters advance only on clk edges with s_tick=1.
- States are IDLE, START, DATA, PARITY, STOP. tx is registered and takes its new value on the same edge that enters or advances the state.
- IDLE:
  - tx=1.
  - On tx_start=1: b_reg<=tx_din; parity reg <= ^tx_din ^ PARITY_ODD; s_cnt<=0; go to START with tx<=0.
  - tx_start is accepted regardless of s_tick, so the start bit may be up to one tick period longer. This is acceptable.
- START:
  - tx=0.
  - On s_tick with s_cnt==BIT_WIDTH-1: s_cnt<=0, n_cnt<=0, go to DATA with tx<=b_reg[0].
  - Otherwise, on s_tick: s_cnt++.
- DATA:
  - tx=b_reg[0].
  - On s_tick with s_cnt==BIT_WIDTH-1: s_cnt<=0 and b_reg<=b_reg>>1 (zero fill).
    - If n_cnt==DBIT-1: n_cnt<=0; go to PARITY (tx<=parity) when PARITY_EN=1, else go to STOP (tx<=1).
    - Otherwise: n_cnt++ and tx<=b_reg[1].
  - Otherwise, on s_tick: s_cnt++.
- PARITY (reachable only when PARITY_EN=1):
  - tx=parity.
  - On s_tick with s_cnt==BIT_WIDTH-1: s_cnt<=0, go to STOP with tx<=1.
- STOP:
  - tx=1.
  - On s_tick with s_cnt==SB_TICK-1: s_cnt<=0, go to IDLE, tx_done<=1 for exactly one clk.
  - Otherwise, on s_tick: s_cnt++.
- tx_done is registered: it is high in the clk after the final stop tick and 0 at all other times.
- tx_busy = (state != IDLE), combinational from the state register. It drops in the same cycle that tx_done is high.
- tx_start while busy is ignored: no queueing, no effect on the frame, tx_din not sampled.
- Back-to-back frames: tx_start asserted in the cycle tx_done=1 is in IDLE and is accepted, so the next start bit begins on the following edge.
- Frame length in s_ticks = BIT_WIDTH*(1+DBIT+PARITY_EN) + SB_TICK. Defaults give 160 s_ticks (176 with parity).
- An illegal state encoding recovers to IDLE on the next clk with tx=1.

Test Plan:
- Reset mid-DATA with s_tick every clk -> tx=1, tx_busy=0, tx_done=0 immediately; no tx_done afterwards; the next tx_start sends a clean frame.
- tx_din=8'hA5, tx_start pulse, s_tick every clk -> tx held for 16 clks each at 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop). tx_done high for 1 clk exactly 160 clks after the start edge. tx_busy high for those 160 clks.
- s_tick every 4th clk, tx_din=8'h3C -> each bit lasts 64 clks; the receiver looped back outputs rx_dout=8'h3C with rx_done.
- tx_start held high for the entire frame with tx_din changing mid-frame -> the first word is sent unaltered. A second frame starts the edge after tx_done, and its first data bit equals bit0 of tx_din sampled in the tx_done cycle.
- PARITY_EN=1, PARITY_ODD=0, tx_din=8'h07 -> parity bit 1 after bit7; frame is 176 ticks. PARITY_ODD=1, tx_din=8'h07 -> parity bit 0.
- SB_TICK=32, tx_din=8'hFF -> the stop high period lasts 32 ticks before tx_done; the line stays 1 in IDLE afterwards.
